// File: rtl/spi_word_receiver.sv
// Oversampling SPI word receiver: synchronises SCK/MOSI/CS_n onto clk, assembles
// WORD_WIDTH-bit words per CS frame and offers them on a valid/ready handshake.
// Optional MISO transmit path enabled by defining SPI_WORD_RECEIVER_MISO_EN.
module spi_word_receiver #(
   parameter int WORD_WIDTH  = 16,
   parameter int SPI_MODE    = 0,
   parameter int MSB_FIRST   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  spi_clk,
   input  logic                  spi_mosi,
   input  logic                  spi_cs_n,
`ifdef SPI_WORD_RECEIVER_MISO_EN
   input  logic [WORD_WIDTH-1:0] tx_data,
   output logic                  spi_miso,
`endif
   output logic [WORD_WIDTH-1:0] data,
   output logic                  data_first,
   output logic                  data_valid,
   input  logic                  data_ready,
   output logic                  overrun,
   input  logic                  overrun_clear,
   output logic                  short_frame
);

   localparam int CW = $clog2(WORD_WIDTH);
   localparam bit SAMPLE_RISE = (SPI_MODE == 0) || (SPI_MODE == 3);
   localparam logic [CW-1:0] LAST_BIT = CW'(WORD_WIDTH - 1);

   logic [SYNC_STAGES-1:0] r_sck_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic                   r_sck_prev;
   logic                   r_cs_prev;
   logic                   r_samp_stb;
   logic                   r_mosi_q;

   logic                   r_active;
   logic                   r_first_word;
   logic [CW-1:0]          r_bit_cnt;
   logic [WORD_WIDTH-1:0]  r_shift;
   logic                   r_word_done;
   logic [WORD_WIDTH-1:0]  r_done_word;
   logic                   r_done_first;
   logic                   r_short;

   logic [WORD_WIDTH-1:0]  r_data;
   logic                   r_data_first;
   logic                   r_data_valid;
   logic                   r_overrun;

   logic                   w_sck;
   logic                   w_cs;
   logic                   w_sck_rise;
   logic                   w_sck_fall;
   logic                   w_samp_edge;
   logic                   w_cs_fall;
   logic                   w_cs_rise;
   logic [WORD_WIDTH-1:0]  w_shift_next;

   assign w_sck       = r_sck_sync[SYNC_STAGES-1];
   assign w_cs        = r_cs_sync[SYNC_STAGES-1];
   assign w_sck_rise  = w_sck & ~r_sck_prev;
   assign w_sck_fall  = ~w_sck & r_sck_prev;
   assign w_samp_edge = SAMPLE_RISE ? w_sck_rise : w_sck_fall;
   assign w_cs_fall   = ~w_cs & r_cs_prev;
   assign w_cs_rise   = w_cs & ~r_cs_prev;
   assign w_shift_next = (MSB_FIRST != 0) ? {r_shift[WORD_WIDTH-2:0], r_mosi_q}
                                          : {r_mosi_q, r_shift[WORD_WIDTH-1:1]};

   // The sample strobe and its MOSI bit are registered once more so that a
   // completed word reaches data_valid SYNC_STAGES+2 edges after SCK is captured.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sck_sync  <= '0;
         r_mosi_sync <= '0;
         r_cs_sync   <= '0;
         r_sck_prev  <= 1'b0;
         r_cs_prev   <= 1'b0;
         r_samp_stb  <= 1'b0;
         r_mosi_q    <= 1'b0;
      end else begin
         r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_clk};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         r_sck_prev  <= w_sck;
         r_cs_prev   <= w_cs;
         r_samp_stb  <= w_samp_edge;
         r_mosi_q    <= r_mosi_sync[SYNC_STAGES-1];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_active     <= 1'b0;
         r_first_word <= 1'b0;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_word_done  <= 1'b0;
         r_done_word  <= '0;
         r_done_first <= 1'b0;
         r_short      <= 1'b0;
      end else begin
         r_word_done <= 1'b0;
         r_short     <= 1'b0;
         if (w_cs_fall) begin
            r_active     <= 1'b1;
            r_first_word <= 1'b1;
            r_bit_cnt    <= '0;
         end else if (w_cs_rise) begin
            r_active  <= 1'b0;
            r_bit_cnt <= '0;
            r_short   <= (r_bit_cnt != '0);
         end else if (r_samp_stb && r_active) begin
            r_shift <= w_shift_next;
            if (r_bit_cnt == LAST_BIT) begin
               r_bit_cnt    <= '0;
               r_word_done  <= 1'b1;
               r_done_word  <= w_shift_next;
               r_done_first <= r_first_word;
               r_first_word <= 1'b0;
            end else begin
               r_bit_cnt <= r_bit_cnt + 1'b1;
            end
         end
      end
   end

   // Output stage: a new word may replace the held one only when it is being
   // consumed on the same edge; otherwise it is dropped and overrun latched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_data       <= '0;
         r_data_first <= 1'b0;
         r_data_valid <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         if (r_word_done && (!r_data_valid || data_ready)) begin
            r_data       <= r_done_word;
            r_data_first <= r_done_first;
            r_data_valid <= 1'b1;
         end else if (data_ready) begin
            r_data_valid <= 1'b0;
         end
         if (r_word_done && r_data_valid && !data_ready) begin
            r_overrun <= 1'b1;
         end else if (overrun_clear) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign data        = r_data;
   assign data_first  = r_data_first;
   assign data_valid  = r_data_valid;
   assign overrun     = r_overrun;
   assign short_frame = r_short;

`ifdef SPI_WORD_RECEIVER_MISO_EN
   localparam bit CPHA = (SPI_MODE % 2) == 1;

   logic [WORD_WIDTH-1:0] r_tx_shift;
   logic [CW-1:0]         r_tx_cnt;
   logic                  r_tx_primed;
   logic                  w_nsamp_edge;

   assign w_nsamp_edge = SAMPLE_RISE ? w_sck_fall : w_sck_rise;

   // With CPHA=1 the first non-sample edge only presents bit 0; later ones advance.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tx_shift  <= '0;
         r_tx_cnt    <= '0;
         r_tx_primed <= 1'b0;
      end else if (w_cs_fall) begin
         r_tx_shift  <= tx_data;
         r_tx_cnt    <= '0;
         r_tx_primed <= !CPHA;
      end else if (w_nsamp_edge && r_active) begin
         if (!r_tx_primed) begin
            r_tx_primed <= 1'b1;
         end else if (r_tx_cnt == LAST_BIT) begin
            r_tx_shift <= tx_data;
            r_tx_cnt   <= '0;
         end else begin
            r_tx_shift <= (MSB_FIRST != 0) ? {r_tx_shift[WORD_WIDTH-2:0], 1'b0}
                                           : {1'b0, r_tx_shift[WORD_WIDTH-1:1]};
            r_tx_cnt   <= r_tx_cnt + 1'b1;
         end
      end
   end

   assign spi_miso = r_active & ~w_cs &
                     ((MSB_FIRST != 0) ? r_tx_shift[WORD_WIDTH-1] : r_tx_shift[0]);
`endif

endmodule

// File: tb/tb_spi_word_receiver.sv
// Directed bench for spi_word_receiver: three instances (mode 0 MSB-first,
// mode 1 LSB-first, mode 3 MSB-first) share one SPI bus; clk = 8x SCK.
module tb_spi_word_receiver;

   localparam int S = 2;
   localparam int LAT = S + 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sck = 1'b0;
   logic        mosi = 1'b0;
   logic        cs_n = 1'b1;
   logic [2:0]  rdy = 3'b000;
   logic        clr_man = 1'b0;
   logic        clr_auto = 1'b0;
   logic        clr_arm = 1'b0;
   logic        clr;
   logic [15:0] d [3];
   logic        f [3];
   logic        v [3];
   logic        ovr [3];
   logic        sf [3];
`ifdef SPI_WORD_RECEIVER_MISO_EN
   logic [15:0] tx_data = 16'h0000;
   logic        miso0, miso1, miso3;
   logic [15:0] miso_cap = 16'h0000;
`endif

   assign clr = clr_man | clr_auto;

   spi_word_receiver #(.WORD_WIDTH(16), .SPI_MODE(0), .MSB_FIRST(1), .SYNC_STAGES(S)) u_m0 (
      .clk(clk), .reset(rst_n), .spi_clk(sck), .spi_mosi(mosi), .spi_cs_n(cs_n),
`ifdef SPI_WORD_RECEIVER_MISO_EN
      .tx_data(tx_data), .spi_miso(miso0),
`endif
      .data(d[0]), .data_first(f[0]), .data_valid(v[0]), .data_ready(rdy[0]),
      .overrun(ovr[0]), .overrun_clear(clr), .short_frame(sf[0]));

   spi_word_receiver #(.WORD_WIDTH(16), .SPI_MODE(1), .MSB_FIRST(0), .SYNC_STAGES(S)) u_m1 (
      .clk(clk), .reset(rst_n), .spi_clk(sck), .spi_mosi(mosi), .spi_cs_n(cs_n),
`ifdef SPI_WORD_RECEIVER_MISO_EN
      .tx_data(tx_data), .spi_miso(miso1),
`endif
      .data(d[1]), .data_first(f[1]), .data_valid(v[1]), .data_ready(rdy[1]),
      .overrun(ovr[1]), .overrun_clear(clr), .short_frame(sf[1]));

   spi_word_receiver #(.WORD_WIDTH(16), .SPI_MODE(3), .MSB_FIRST(1), .SYNC_STAGES(S)) u_m3 (
      .clk(clk), .reset(rst_n), .spi_clk(sck), .spi_mosi(mosi), .spi_cs_n(cs_n),
`ifdef SPI_WORD_RECEIVER_MISO_EN
      .tx_data(tx_data), .spi_miso(miso3),
`endif
      .data(d[2]), .data_first(f[2]), .data_valid(v[2]), .data_ready(rdy[2]),
      .overrun(ovr[2]), .overrun_clear(clr), .short_frame(sf[2]));

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   int t_last = -100;
   always @(posedge clk) cyc = cyc + 1;

   // Clear pulse aimed at the exact edge where the pending word completes.
   always @(posedge clk) begin
      #1;
      clr_auto = clr_arm && (cyc == t_last + LAT - 1);
   end

   // ---------------- monitors ----------------
   int   vrise [3] = '{0, 0, 0};
   int   rise_cyc [3] = '{0, 0, 0};
   int   sf_cnt [3] = '{0, 0, 0};
   int   hs_cnt [3] = '{0, 0, 0};
   logic [15:0] hs_data [3];
   logic v_d [3] = '{1'b0, 1'b0, 1'b0};
   logic mon3_en = 1'b0;
   logic [16:0] exp_q [$];
   logic [16:0] got_q [$];

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (v[i] && !v_d[i]) begin
            rise_cyc[i] = cyc;
            vrise[i]++;
         end
         v_d[i] = v[i];
         if (sf[i]) sf_cnt[i]++;
         if (v[i] && rdy[i]) begin
            hs_cnt[i]++;
            hs_data[i] = d[i];
            if (i == 2 && mon3_en) got_q.push_back({f[i], d[i]});
         end
      end
   end

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic half();
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic cs_low(input int mode);
      sck = (mode >= 2);
      half();
      cs_n = 1'b0;
      half();
   endtask

   task automatic cs_high();
      half();
      cs_n = 1'b1;
      half();
      half();
   endtask

   // Bits go out MSB of w first; nbits of them.
   task automatic shift_word(input int mode, input logic [15:0] w, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         if ((mode % 2) == 0) begin
            mosi = w[15-i];
            half();
`ifdef SPI_WORD_RECEIVER_MISO_EN
            miso_cap = {miso_cap[14:0], miso0};
`endif
            sck = ~sck;
            if (i == nbits - 1) t_last = cyc;
            half();
            sck = ~sck;
         end else begin
            sck = ~sck;
            mosi = w[15-i];
            half();
            sck = ~sck;
            if (i == nbits - 1) t_last = cyc;
            half();
         end
      end
   endtask

   task automatic drain_all();
      rdy = 3'b111;
      clr_man = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      rdy = 3'b000;
      clr_man = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      int          idx;
      int          mode;
      logic [15:0] stream;
      logic [15:0] exp_data;
   } vec_t;

   vec_t vecs [6];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int hb, sb, vb;
      logic [16:0] g, e;

      vecs[0] = '{0, 0, 16'hA5C3, 16'hA5C3};
      vecs[1] = '{0, 0, 16'h0000, 16'h0000};
      vecs[2] = '{0, 0, 16'hFFFF, 16'hFFFF};
      vecs[3] = '{1, 1, 16'h8000, 16'h0001};
      vecs[4] = '{1, 1, 16'hA5C3, 16'hC3A5};
      vecs[5] = '{2, 3, 16'h5A3C, 16'h5A3C};

      repeat (3) @(posedge clk);
      #1;
      check("reset_data", 32'(d[0]), 32'h0);
      check("reset_first", 32'(f[0]), 32'h0);
      check("reset_valid", 32'(v[0]), 32'h0);
      check("reset_overrun", 32'(ovr[0]), 32'h0);
      check("reset_short", 32'(sf[0]), 32'h0);
      rst_n = 1'b1;
      half();
      check("post_reset_no_short", 32'(sf_cnt[0]), 32'h0);

      // Single-word frames: data, first flag, latency, release.
      for (int k = 0; k < 6; k++) begin
         drain_all();
         vb = vrise[vecs[k].idx];
         cs_low(vecs[k].mode);
         shift_word(vecs[k].mode, vecs[k].stream, 16);
         cs_high();
         check($sformatf("vec%0d_valid_rise", k), 32'(vrise[vecs[k].idx] - vb), 32'd1);
         check($sformatf("vec%0d_data", k), 32'(d[vecs[k].idx]), 32'(vecs[k].exp_data));
         check($sformatf("vec%0d_first", k), 32'(f[vecs[k].idx]), 32'd1);
         check($sformatf("vec%0d_latency", k), 32'(rise_cyc[vecs[k].idx] - t_last), 32'(LAT));
         rdy[vecs[k].idx] = 1'b1;
         @(posedge clk);
         #1;
         rdy = 3'b000;
         check($sformatf("vec%0d_valid_drop", k), 32'(v[vecs[k].idx]), 32'd0);
      end

      // Mode 3: two words in one frame, consumer always ready.
      drain_all();
      exp_q.push_back({1'b1, 16'h1234});
      exp_q.push_back({1'b0, 16'hBEEF});
      mon3_en = 1'b1;
      rdy[2] = 1'b1;
      cs_low(3);
      shift_word(3, 16'h1234, 16);
      shift_word(3, 16'hBEEF, 16);
      cs_high();
      rdy[2] = 1'b0;
      mon3_en = 1'b0;
      check("m3_handshakes", 32'(got_q.size()), 32'd2);
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         check("m3_word", 32'(g), 32'(e));
      end

      // Overrun: second word dropped, first kept; set beats a same-edge clear.
      drain_all();
      hb = hs_cnt[0];
      cs_low(0);
      shift_word(0, 16'h1111, 16);
      shift_word(0, 16'h2222, 16);
      cs_high();
      check("ovr_data_kept", 32'(d[0]), 32'h1111);
      check("ovr_first", 32'(f[0]), 32'd1);
      check("ovr_valid", 32'(v[0]), 32'd1);
      check("ovr_set", 32'(ovr[0]), 32'd1);
      clr_man = 1'b1;
      @(posedge clk);
      #1;
      clr_man = 1'b0;
      check("ovr_cleared", 32'(ovr[0]), 32'd0);
      clr_arm = 1'b1;
      cs_low(0);
      shift_word(0, 16'h3333, 16);
      cs_high();
      clr_arm = 1'b0;
      check("ovr_set_wins", 32'(ovr[0]), 32'd1);
      check("ovr_data_still", 32'(d[0]), 32'h1111);
      clr_man = 1'b1;
      rdy[0] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rdy[0] = 1'b0;
      clr_man = 1'b0;
      check("ovr_one_handshake", 32'(hs_cnt[0] - hb), 32'd1);
      check("ovr_hs_data", 32'(hs_data[0]), 32'h1111);
      check("ovr_valid_low", 32'(v[0]), 32'd0);

      // Short frame: 5 bits then CS high.
      drain_all();
      sb = sf_cnt[0];
      vb = vrise[0];
      cs_low(0);
      shift_word(0, 16'hF800, 5);
      cs_high();
      check("short_pulse_width", 32'(sf_cnt[0] - sb), 32'd1);
      check("short_no_valid", 32'(vrise[0] - vb), 32'd0);
      cs_low(0);
      shift_word(0, 16'h00FF, 16);
      cs_high();
      check("after_short_data", 32'(d[0]), 32'h00FF);
      check("after_short_first", 32'(f[0]), 32'd1);
      check("full_frame_no_short", 32'(sf_cnt[0] - sb), 32'd1);

      // Reset mid-frame, then bits without a fresh CS fall are ignored.
      drain_all();
      cs_low(0);
      shift_word(0, 16'hFFFF, 9);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midreset_data", 32'(d[0]), 32'h0);
      check("midreset_valid", 32'(v[0]), 32'h0);
      check("midreset_first", 32'(f[0]), 32'h0);
      half();
      rst_n = 1'b1;
      half();
      vb = vrise[0];
      shift_word(0, 16'h5555, 16);
      half();
      check("no_word_without_cs_fall", 32'(vrise[0] - vb), 32'd0);
      cs_n = 1'b1;
      half();
      half();
`ifdef SPI_WORD_RECEIVER_MISO_EN
      tx_data = 16'h8001;
      miso_cap = 16'h0000;
`endif
      cs_low(0);
      shift_word(0, 16'hCAFE, 16);
      cs_high();
      check("post_reset_data", 32'(d[0]), 32'hCAFE);
      check("post_reset_first", 32'(f[0]), 32'd1);
`ifdef SPI_WORD_RECEIVER_MISO_EN
      check("miso_word", 32'(miso_cap), 32'h8001);
      check("miso_idle", 32'(miso0), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
